// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache request, refill/ack and memory-port signals of the arbiter
interface cache_mem_arbiter_if #(parameter int LINE_WORDS = 4);
    localparam int IW = $clog2(LINE_WORDS);
    logic          ic_req;
    logic [31:0]   ic_addr;
    logic          dc_req;
    logic          dc_we;
    logic [31:0]   dc_addr;
    logic [31:0]   dc_wdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          ic_fill_we;
    logic          dc_fill_we;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic          ic_ack;
    logic          dc_ack;
    logic          waiting;
    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, ic_fill_we, dc_fill_we,
               fill_idx, fill_data, ic_ack, dc_ack, waiting
    );
    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, ic_fill_we, dc_fill_we,
               fill_idx, fill_data, ic_ack, dc_ack, waiting
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one memory port between I-cache and D-cache refills/stores
module cache_mem_arbiter #(parameter int LINE_WORDS = 4) (
    input logic clk,
    input logic rst,
    cache_mem_arbiter_if.master bus
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int B = IW + 2;
    typedef enum logic [2:0] {IDLE, IC_FILL, DC_FILL, DC_WRITE, DONE} state_t;
    state_t state, next;
    logic [IW-1:0] cnt;
    logic owner, last;
    logic gnt_dc, gnt_ic, fill, wr;
    // on a tie the grant goes to whichever side was not served last
    assign gnt_dc = bus.dc_req & (~bus.ic_req | ~last);
    assign gnt_ic = bus.ic_req & ~gnt_dc;
    assign fill = state == IC_FILL || state == DC_FILL;
    assign wr = state == DC_WRITE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            owner <= 1'b0;
            last <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && (gnt_dc || gnt_ic)) begin
                cnt <= '0;
                owner <= gnt_dc;
                last <= gnt_dc;
            end else if (fill && bus.mem_ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:             next = gnt_dc ? (bus.dc_we ? DC_WRITE : DC_FILL) : gnt_ic ? IC_FILL : IDLE;
            IC_FILL, DC_FILL: next = (bus.mem_ready && &cnt) ? DONE : state;
            DC_WRITE:         next = bus.mem_ready ? DONE : DC_WRITE;
            default:          next = IDLE;
        endcase
    end
    always_comb begin
        bus.mem_req = fill | wr;
        bus.mem_we = wr;
        bus.mem_addr = fill ? {(state == DC_FILL ? bus.dc_addr[31:B] : bus.ic_addr[31:B]), cnt, 2'b00}
                     : wr ? {bus.dc_addr[31:2], 2'b00} : '0;
        bus.mem_wdata = wr ? bus.dc_wdata : '0;
        bus.ic_fill_we = state == IC_FILL && bus.mem_ready;
        bus.dc_fill_we = state == DC_FILL && bus.mem_ready;
        bus.fill_idx = fill ? cnt : '0;
        bus.fill_data = fill ? bus.mem_rdata : '0;
        bus.ic_ack = state == DONE && !owner;
        bus.dc_ack = state == DONE && owner;
        bus.waiting = (bus.ic_req & ~bus.ic_ack) | (bus.dc_req & ~bus.dc_ack);
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios for the cache memory arbiter, inputs driven and outputs checked on negedge
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    cache_mem_arbiter_if #(.LINE_WORDS(4)) bus();
    cache_mem_arbiter #(.LINE_WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic test_reset();
        rst = 1'b1;
        {bus.ic_req, bus.dc_req, bus.dc_we, bus.mem_ready} = '0;
        {bus.ic_addr, bus.dc_addr, bus.dc_wdata, bus.mem_rdata} = '0;
        @(negedge clk); #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.ic_fill_we, bus.dc_fill_we, bus.ic_ack, bus.dc_ack, bus.waiting} !== 7'b0 || bus.mem_addr !== 32'h0)
            begin errors++; $display("FAIL reset_outputs: got req=%b ack=%b/%b waiting=%b addr=%h, expected all 0", bus.mem_req, bus.ic_ack, bus.dc_ack, bus.waiting, bus.mem_addr); end
        bus.ic_req = 1'b1; #1;
        checks++;
        if (bus.waiting !== 1'b1 || bus.mem_req !== 1'b0)
            begin errors++; $display("FAIL reset_waiting: got waiting=%b mem_req=%b, expected 1/0", bus.waiting, bus.mem_req); end
        bus.ic_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bus.ic_req = 1'b1; bus.ic_addr = 32'h4000;
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h8010; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.dc_fill_we !== 1'b1 || bus.ic_fill_we !== 1'b0 || bus.mem_addr !== 32'(32'h8010 + 4 * i))
                begin errors++; $display("FAIL tie_dc_first beat %0d: got dc_we=%b ic_we=%b addr=%h, expected 1/0/%h", i, bus.dc_fill_we, bus.ic_fill_we, bus.mem_addr, 32'h8010 + 4 * i); end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.dc_ack !== 1'b1 || bus.ic_ack !== 1'b0 || bus.waiting !== 1'b1)
            begin errors++; $display("FAIL tie_dc_ack: got dc_ack=%b ic_ack=%b waiting=%b, expected 1/0/1", bus.dc_ack, bus.ic_ack, bus.waiting); end
        bus.dc_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.waiting !== 1'b1)
            begin errors++; $display("FAIL tie_idle: got mem_req=%b waiting=%b, expected 0/1", bus.mem_req, bus.waiting); end
        @(negedge clk); #1;
        checks++;
        if (bus.ic_fill_we !== 1'b1 || bus.mem_addr !== 32'h4000)
            begin errors++; $display("FAIL tie_ic_second: got ic_we=%b addr=%h, expected 1/00004000", bus.ic_fill_we, bus.mem_addr); end
        for (int i = 0; i < 20 && bus.ic_ack !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.ic_ack !== 1'b1) begin errors++; $display("FAIL tie_ic_ack: got ic_ack=%b, expected 1 within 20 cycles", bus.ic_ack); end
        bus.ic_req = 1'b0;
        @(negedge clk);
        bus.ic_req = 1'b1;
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h3000; bus.dc_wdata = 32'h55;
        @(negedge clk); #1;
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h3000 || bus.ic_fill_we !== 1'b0)
            begin errors++; $display("FAIL tie2_dc_first: got we=%b addr=%h ic_we=%b, expected 1/00003000/0", bus.mem_we, bus.mem_addr, bus.ic_fill_we); end
        @(negedge clk); #1;
        checks++;
        if (bus.dc_ack !== 1'b1) begin errors++; $display("FAIL tie2_dc_ack: got %b, expected 1", bus.dc_ack); end
        bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        for (int i = 0; i < 20 && bus.ic_ack !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.ic_ack !== 1'b1) begin errors++; $display("FAIL tie2_ic_ack: got ic_ack=%b, expected 1 within 20 cycles", bus.ic_ack); end
        bus.ic_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ic_refill();
        bus.ic_addr = 32'h1234; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_rdata = 32'(32'hA000_0000 + i); #1;
            checks++;
            if (bus.mem_addr !== 32'(32'h1230 + 4 * i) || bus.ic_fill_we !== 1'b1 || bus.fill_idx !== 2'(i) || bus.fill_data !== 32'(32'hA000_0000 + i) || bus.waiting !== 1'b1 || bus.mem_we !== 1'b0)
                begin errors++; $display("FAIL ic_beat %0d: got addr=%h we=%b idx=%0d data=%h waiting=%b, expected %h/1/%0d/%h/1", i, bus.mem_addr, bus.ic_fill_we, bus.fill_idx, bus.fill_data, bus.waiting, 32'h1230 + 4 * i, i, 32'hA000_0000 + i); end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ic_ack !== 1'b1 || bus.mem_req !== 1'b0 || bus.ic_fill_we !== 1'b0 || bus.waiting !== 1'b0)
            begin errors++; $display("FAIL ic_ack: got ack=%b req=%b fill=%b waiting=%b, expected 1/0/0/0", bus.ic_ack, bus.mem_req, bus.ic_fill_we, bus.waiting); end
        bus.ic_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.ic_ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.waiting !== 1'b0 || bus.mem_addr !== 32'h0)
            begin errors++; $display("FAIL ic_after_ack: got ack=%b req=%b waiting=%b addr=%h, expected all 0", bus.ic_ack, bus.mem_req, bus.waiting, bus.mem_addr); end
    endtask

    task automatic test_wait_states();
        logic [6:0] rdy = 7'b1110100;
        int off [7] = '{0, 0, 0, 4, 4, 8, 12};
        int nfill = 0;
        bus.ic_addr = 32'h5008; bus.ic_req = 1'b1; bus.mem_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.mem_ready = rdy[k]; #1;
            nfill += int'(bus.ic_fill_we);
            checks++;
            if (bus.mem_addr !== 32'(32'h5000 + off[k]) || bus.ic_fill_we !== rdy[k] || bus.ic_ack !== 1'b0)
                begin errors++; $display("FAIL wait_cycle %0d: got addr=%h fill=%b ack=%b, expected %h/%b/0", k, bus.mem_addr, bus.ic_fill_we, bus.ic_ack, 32'h5000 + off[k], rdy[k]); end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ic_ack !== 1'b1 || nfill !== 4)
            begin errors++; $display("FAIL wait_ack: got ack=%b fills=%0d, expected 1/4", bus.ic_ack, nfill); end
        bus.ic_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dc_store();
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h2007; bus.dc_wdata = 32'hDEADBEEF; bus.mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h2004 || bus.mem_wdata !== 32'hDEADBEEF || bus.dc_fill_we !== 1'b0 || bus.ic_fill_we !== 1'b0)
            begin errors++; $display("FAIL store_beat: got req=%b we=%b addr=%h wdata=%h fills=%b%b, expected 1/1/00002004/deadbeef/00", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ic_fill_we, bus.dc_fill_we); end
        @(negedge clk); #1;
        checks++;
        if (bus.dc_ack !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.dc_fill_we !== 1'b0)
            begin errors++; $display("FAIL store_ack: got ack=%b req=%b addr=%h wdata=%h fill=%b, expected 1/0/0/0/0", bus.dc_ack, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.dc_fill_we); end
        bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.dc_ack !== 1'b0 || bus.mem_req !== 1'b0)
            begin errors++; $display("FAIL store_idle: got ack=%b req=%b, expected 0/0", bus.dc_ack, bus.mem_req); end
    endtask

    task automatic test_reset_mid();
        bus.ic_addr = 32'h6000; bus.ic_req = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        checks++;
        if (bus.fill_idx !== 2'd2 || bus.mem_addr !== 32'h6008)
            begin errors++; $display("FAIL rmid_beat2: got idx=%0d addr=%h, expected 2/00006008", bus.fill_idx, bus.mem_addr); end
        rst = 1'b1; #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.ic_fill_we, bus.dc_fill_we, bus.ic_ack, bus.dc_ack} !== 6'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.fill_idx !== 2'd0 || bus.fill_data !== 32'h0 || bus.waiting !== 1'b1)
            begin errors++; $display("FAIL rmid_outputs: got req=%b fill=%b addr=%h idx=%0d data=%h ack=%b waiting=%b, expected zeros with waiting=1", bus.mem_req, bus.ic_fill_we, bus.mem_addr, bus.fill_idx, bus.fill_data, bus.ic_ack, bus.waiting); end
        @(negedge clk); #1;
        checks++;
        if (bus.ic_ack !== 1'b0 || bus.mem_req !== 1'b0)
            begin errors++; $display("FAIL rmid_no_ack: got ack=%b req=%b, expected 0/0", bus.ic_ack, bus.mem_req); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.ic_fill_we !== 1'b1 || bus.fill_idx !== 2'd0 || bus.mem_addr !== 32'h6000)
            begin errors++; $display("FAIL rmid_restart: got fill=%b idx=%0d addr=%h, expected 1/0/00006000", bus.ic_fill_we, bus.fill_idx, bus.mem_addr); end
        for (int i = 0; i < 20 && bus.ic_ack !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.ic_ack !== 1'b1) begin errors++; $display("FAIL rmid_ack: got ic_ack=%b, expected 1 within 20 cycles", bus.ic_ack); end
        bus.ic_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dc_pending();
        bus.ic_addr = 32'h7000; bus.ic_req = 1'b1; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h9000; end
            #1;
            checks++;
            if (bus.waiting !== 1'b1 || bus.ic_fill_we !== 1'b1 || bus.dc_fill_we !== 1'b0 || bus.mem_addr !== 32'(32'h7000 + 4 * i))
                begin errors++; $display("FAIL pend_ic_beat %0d: got waiting=%b ic=%b dc=%b addr=%h, expected 1/1/0/%h", i, bus.waiting, bus.ic_fill_we, bus.dc_fill_we, bus.mem_addr, 32'h7000 + 4 * i); end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.ic_ack !== 1'b1 || bus.dc_ack !== 1'b0 || bus.waiting !== 1'b1)
            begin errors++; $display("FAIL pend_ic_ack: got ic=%b dc=%b waiting=%b, expected 1/0/1", bus.ic_ack, bus.dc_ack, bus.waiting); end
        bus.ic_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.dc_fill_we !== 1'b0 || bus.waiting !== 1'b1)
            begin errors++; $display("FAIL pend_idle: got req=%b dc_fill=%b waiting=%b, expected 0/0/1", bus.mem_req, bus.dc_fill_we, bus.waiting); end
        @(negedge clk); #1;
        checks++;
        if (bus.dc_fill_we !== 1'b1 || bus.mem_addr !== 32'h9000)
            begin errors++; $display("FAIL pend_dc_grant: got dc_fill=%b addr=%h, expected 1/00009000", bus.dc_fill_we, bus.mem_addr); end
        for (int i = 0; i < 20 && bus.dc_ack !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.dc_ack !== 1'b1) begin errors++; $display("FAIL pend_dc_ack: got dc_ack=%b, expected 1 within 20 cycles", bus.dc_ack); end
        bus.dc_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_ic_refill();
        test_wait_states();
        test_dc_store();
        test_reset_mid();
        test_dc_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single external memory port between the I-cache refill path and the D-cache refill/write-through path of the RV32I cached pipeline. It runs a round-robin grant FSM, issues multi-beat line refills and single-beat stores, and streams refill words back to the owning cache. It also drives the pipeline-wide `waiting` stall that freezes the stage registers while any cache miss or store is outstanding.

## Interface

- `LINE_WORDS`, default 4: words per cache line and beats per refill; must be a power of 2, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ic_req`  in  1  I-cache miss request; held high until `ic_ack`.
- `ic_addr`  in  32  I-cache miss address; stable while `ic_req` is high.
- `dc_req`  in  1  D-cache request; held high until `dc_ack`.
- `dc_we`  in  1  1 = write-through store, 0 = line refill; stable while `dc_req` is high.
- `dc_addr`  in  32  D-cache address.
- `dc_wdata`  in  32  store data.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_wdata`  out  32  write data.
- `mem_ready`  in  1  beat completes this cycle; read data is valid on `mem_rdata`.
- `mem_rdata`  in  32  read data.
- `ic_fill_we`  out  1  write `fill_data` into I-cache line word `fill_idx`.
- `dc_fill_we`  out  1  same, for D-cache.
- `fill_idx`  out  log2(LINE_WORDS)  word index within the line.
- `fill_data`  out  32  equal to `mem_rdata`.
- `ic_ack`  out  1  one-cycle pulse: I-cache transaction done.
- `dc_ack`  out  1  one-cycle pulse: D-cache transaction done.
- `waiting`  out  1  pipeline stall.

## Operation

- FSM states:
  - **IDLE**
  - **IC_FILL**
  - **DC_FILL**
  - **DC_WRITE**
  - **DONE**
- Register `owner` (0 = IC, 1 = DC) records the current grant.
- Register `last` records the most recent grant.
- Beat counter `cnt` is log2(LINE_WORDS) bits wide.
- Arbitration happens in IDLE only:
  - One request pending: grant it.
  - Both pending: grant the one not equal to `last`.
  - On grant: `cnt` <= 0, `last` <= grantee.
  - The DC grant goes to DC_WRITE if `dc_we`, else to DC_FILL.
- Fill states:
  - `mem_req` = 1, `mem_we` = 0.
  - `mem_addr` = {addr[31:B], cnt, 2'b00}, where B = log2(LINE_WORDS)+2.
  - On `mem_ready`: `cnt` increments, and the owner's fill write-enable is high that cycle with `fill_idx` = `cnt`.
  - After the beat with `cnt` = LINE_WORDS-1 completes, go to DONE.
- DC_WRITE:
  - `mem_req` = 1, `mem_we` = 1.
  - `mem_addr` = {dc_addr[31:2], 2'b00}, `mem_wdata` = `dc_wdata`.
  - On `mem_ready`, go to DONE.
- DONE:
  - The owner's ack is high for exactly one cycle, `mem_req` = 0.
  - Next state is IDLE.
  - Requesters drop `req` at the edge that ends the ack cycle. The arbiter never re-grants the same transaction.
- `waiting` = (`ic_req` & ~`ic_ack`) | (`dc_req` & ~`dc_ack`). It is combinational, so the stage registers advance in the ack cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, fill enables and `fill_idx` are decoded from state and `cnt`:
  - Fill enables are 0 outside fill states.
  - `mem_addr` and `mem_wdata` are 0 when `mem_req` = 0.
- `mem_ready` while `mem_req` = 0 is ignored.
- Requests arriving while busy wait in IDLE arbitration. They are never dropped.

## Timing

- Reset, asynchronous, effective immediately and also mid-transaction:
  - State is IDLE, `cnt` = 0, `owner` = 0, `last` = 0 (IC).
  - All outputs are 0 except `waiting`, which follows its inputs.
  - Any partial refill is abandoned, with no ack. The requester re-requests after reset.
- Grant latency is 1 cycle: a request seen in IDLE at cycle T gives `mem_req` high at T+1.
- With `mem_ready` always high:
  - A refill occupies cycles T+1 … T+LINE_WORDS, and the ack comes at T+LINE_WORDS+1.
  - A store has its beat at T+1 and its ack at T+2.
- Wait states: `mem_addr` and `cnt` hold while `mem_ready` = 0.
- Back-to-back: the earliest next `mem_req` is two cycles after the last beat (DONE, then IDLE grant).
- A simultaneous first-ever request goes to DC, because `last` resets to IC.

## Test plan

- **IC refill, LINE_WORDS=4:**
  - Stimulus: `ic_req` with `ic_addr`=0x0000_1234, `mem_ready`=1.
  - Required: `mem_addr` 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; `ic_fill_we` with idx 0..3; `ic_ack` one cycle later; `waiting` low after the ack edge.
- **Simultaneous requests:**
  - Stimulus: `ic_req` and `dc_req` (refill) both asserted.
  - Required: DC served first; IC granted in the IDLE cycle after DC's ack; next tie goes to DC again, since `last` = IC.
- **Wait states:**
  - Stimulus: `mem_ready` pattern 0,0,1,0,1,1,1.
  - Required: `mem_addr` is held during zeros; exactly 4 fill enables; ack follows the fourth ready.
- **D-cache store:**
  - Stimulus: `dc_we`=1, `dc_addr`=0x0000_2007, `dc_wdata`=0xDEADBEEF.
  - Required: one beat with `mem_we`=1, `mem_addr`=0x2004, `mem_wdata`=0xDEADBEEF; `dc_ack` next cycle; no fill enables.
- **Reset mid-refill:**
  - Stimulus: assert `rst` after beat 2.
  - Required: all outputs 0 immediately with no ack; after release with `ic_req` still high, refill restarts at beat 0.
- **IC fill with DC request pending:**
  - Stimulus: `dc_req` rises during an IC fill.
  - Required: `waiting` high throughout; DC granted exactly after IC's DONE cycle.
